input_port_controller: RTL and testbench

INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

---
 rtl/input_port_controller.sv | 110 +++++++++++
 tb/tb_input_port_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_controller.sv
// Push-button input port: synchronizes and debounces the button, captures the
// switch bank on each press, and hands the word to the processor on in_req.
module input_port_controller #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             button_in,
    input  logic [WIDTH-1:0] switches,
    input  logic             in_req,
    output logic             data_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             btn_level,
    output logic [7:0]       missed_count
);
    typedef enum logic [1:0] {
        IDLE,
        CAPTURED,
        WAIT_RELEASE
    } state_e;

    localparam logic [15:0] CNT_LIMIT = 16'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic [15:0]      cnt_q, cnt_d;
    logic             btn_q, btn_d;
    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       missed_q, missed_d;
    logic             press, transfer, missed_event;

    // The level flips once the synchronized input has disagreed with it long
    // enough that a clean step shows up 2+DEBOUNCE_CYCLES edges after sampling.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = '0;
        btn_d = btn_q;
        if (sync2_q != btn_q) begin
            if (cnt_q == CNT_LIMIT) begin
                btn_d = ~btn_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign press    = btn_d & ~btn_q;
    assign transfer = in_req & valid_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        data_d       = data_q;
        missed_event = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    data_d  = switches;
                    valid_d = 1'b1;
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                missed_event = press;
                if (transfer) begin
                    valid_d = 1'b0;
                    state_d = btn_d ? WAIT_RELEASE : IDLE;
                end
            end
            WAIT_RELEASE: begin
                missed_event = press;
                if (!btn_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        missed_d = (missed_event && (missed_q != 8'hFF)) ? missed_q + 8'd1 : missed_q;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            btn_q    <= 1'b0;
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            missed_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            sync1_q  <= button_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            missed_q <= missed_d;
        end
    end

    assign data_valid   = valid_q;
    assign data_out     = data_q;
    assign btn_level    = btn_q;
    assign missed_count = missed_q;
endmodule

// File: tb/tb_input_port_controller.sv
// Bench for input_port_controller: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_input_port_controller;
    localparam int WIDTH = 16;
    localparam int DB    = 4;
    localparam int HL    = DB + 3;

    logic             clock = 1'b0;
    logic             n_reset = 1'b1;
    logic             button_in = 1'b0;
    logic [WIDTH-1:0] switches = '0;
    logic             in_req = 1'b0;
    logic             data_valid;
    logic [WIDTH-1:0] data_out;
    logic             btn_level;
    logic [7:0]       missed_count;

    input_port_controller #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .button_in    (button_in),
        .switches     (switches),
        .in_req       (in_req),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .btn_level    (btn_level),
        .missed_count (missed_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: raw button history, level flips when the DB+1 samples
    // seen through the two-edge synchronizer all disagree with the current level.
    logic             hist [HL] = '{default: 1'b0};
    logic             m_level = 1'b0;
    logic             m_pend  = 1'b0;
    logic             m_wait  = 1'b0;
    logic [WIDTH-1:0] m_word  = '0;
    int               m_missed = 0;
    logic             m_flip, m_press, m_xfer;

    initial forever begin
        @(posedge clock or negedge n_reset);
        if (!n_reset) begin
            for (int i = 0; i < HL; i++) hist[i] = 1'b0;
            m_level  = 1'b0;
            m_pend   = 1'b0;
            m_wait   = 1'b0;
            m_word   = '0;
            m_missed = 0;
        end else begin
            for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = button_in;
            m_flip = 1'b1;
            for (int i = 2; i <= DB + 2; i++) if (hist[i] == m_level) m_flip = 1'b0;
            m_xfer = in_req && m_pend;
            if (m_flip) m_level = ~m_level;
            m_press = m_flip && m_level;
            if (!m_pend && !m_wait) begin
                if (m_press) begin
                    m_pend = 1'b1;
                    m_word = switches;
                end
            end else begin
                if (m_press && m_missed < 255) m_missed++;
                if (m_pend) begin
                    if (m_xfer) begin
                        m_pend = 1'b0;
                        m_wait = m_level;
                    end
                end else if (!m_level) begin
                    m_wait = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        check("cyc_data_valid", 32'(data_valid), 32'(m_pend));
        check("cyc_data_out", 32'(data_out), 32'(m_word));
        check("cyc_btn_level", 32'(btn_level), 32'(m_level));
        check("cyc_missed_count", 32'(missed_count), 32'(m_missed));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int pat [7] = '{1, 1, 1, 0, 1, 1, 0};
        int hold = 0;

        #1 n_reset = 1'b0;
        #2;
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_missed", 32'(missed_count), 32'd0);
        cycles(2);
        n_reset = 1'b1;
        cycles(3);

        // Glitch rejection
        for (int i = 0; i < 7; i++) begin
            button_in = pat[i][0];
            cycles(1);
        end
        cycles(10);
        check("v2_level", 32'(btn_level), 32'd0);
        check("v2_valid", 32'(data_valid), 32'd0);

        // Single press: capture exactly on edge 6
        switches  = 16'hA5C3;
        button_in = 1'b1;
        repeat (6) @(posedge clock);
        #1 check("v1_edge5_valid", 32'(data_valid), 32'd0);
        check("v1_edge5_level", 32'(btn_level), 32'd0);
        @(posedge clock);
        #1 check("v1_edge6_valid", 32'(data_valid), 32'd1);
        check("v1_edge6_data", 32'(data_out), 32'hA5C3);
        check("v1_edge6_level", 32'(btn_level), 32'd1);
        @(negedge clock);
        switches = 16'h5555;
        cycles(20);
        check("v1_hold_valid", 32'(data_valid), 32'd1);
        check("v1_hold_data", 32'(data_out), 32'hA5C3);

        // Handshake, then release and re-press
        in_req = 1'b1;
        @(posedge clock);
        #1 check("v3_valid_clear", 32'(data_valid), 32'd0);
        @(negedge clock);
        in_req = 1'b0;
        cycles(5);
        check("v3_wait_no_capture", 32'(data_valid), 32'd0);
        switches  = 16'h0001;
        button_in = 1'b0;
        cycles(12);
        check("v3_released", 32'(btn_level), 32'd0);
        button_in = 1'b1;
        cycles(12);
        check("v3_recap_valid", 32'(data_valid), 32'd1);
        check("v3_recap_data", 32'(data_out), 32'h0001);

        // Same-edge transfer and press
        button_in = 1'b0;
        cycles(12);
        button_in = 1'b1;
        switches  = 16'hBEEF;
        repeat (6) @(negedge clock);
        in_req = 1'b1;
        @(posedge clock);
        #1 check("v5_valid", 32'(data_valid), 32'd0);
        check("v5_missed", 32'(missed_count), 32'd1);
        check("v5_level", 32'(btn_level), 32'd1);
        check("v5_data", 32'(data_out), 32'h0001);
        @(negedge clock);
        in_req = 1'b0;
        cycles(5);
        check("v5_wait_no_capture", 32'(data_valid), 32'd0);
        button_in = 1'b0;
        cycles(12);
        switches  = 16'h1234;
        button_in = 1'b1;
        cycles(12);
        check("v5_recap_data", 32'(data_out), 32'h1234);
        button_in = 1'b0;
        cycles(12);

        // Missed-press saturation with a word pending
        for (int i = 0; i < 300; i++) begin
            switches  = 16'($urandom);
            button_in = 1'b1;
            cycles(8);
            button_in = 1'b0;
            cycles(8);
        end
        check("v4_missed_sat", 32'(missed_count), 32'd255);
        check("v4_data_kept", 32'(data_out), 32'h1234);
        check("v4_valid_kept", 32'(data_valid), 32'd1);

        // Asynchronous reset between edges, button held through release
        button_in = 1'b1;
        cycles(12);
        @(posedge clock);
        #2 n_reset = 1'b0;
        #1;
        check("v6_async_valid", 32'(data_valid), 32'd0);
        check("v6_async_data", 32'(data_out), 32'd0);
        check("v6_async_level", 32'(btn_level), 32'd0);
        check("v6_async_missed", 32'(missed_count), 32'd0);
        @(negedge clock);
        n_reset  = 1'b1;
        switches = 16'hC0DE;
        repeat (6) @(posedge clock);
        #1 check("v6_edge5_valid", 32'(data_valid), 32'd0);
        @(posedge clock);
        #1 check("v6_edge6_valid", 32'(data_valid), 32'd1);
        check("v6_edge6_data", 32'(data_out), 32'hC0DE);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (hold == 0) begin
                button_in = 1'($urandom_range(1, 0));
                hold      = int'($urandom_range(12, 1));
            end else begin
                hold--;
            end
            in_req = ($urandom_range(3, 0) == 0);
            if ($urandom_range(7, 0) == 0) switches = 16'($urandom);
            if ($urandom_range(999, 0) == 0) begin
                #2 n_reset = 1'b0;
                #1 n_reset = 1'b1;
            end
        end
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
